// File: rtl/fpu_sequencer.sv
// Command sequencer for the byte-wide FPU register bus: writes operands, op and start,
// waits for end-of-command, reads the 32-bit result back and completes the end handshake.
module fpu_sequencer #(
    parameter int RD_WAIT = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [7:0]  req_op,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        seq_busy,
    output logic        fpu_cs,
    output logic        fpu_rd,
    output logic        fpu_wr,
    output logic [3:0]  fpu_addr,
    output logic [7:0]  fpu_dout,
    input  logic [7:0]  fpu_din,
    input  logic        fpu_cmd_end,
    output logic        fpu_end_ack
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int WW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_WAIT_END,
        ST_RD_BYTE,
        ST_RD_END,
        ST_ACK,
        ST_ACK_WAIT,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [3:0]      r_idx;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [7:0]      r_op;
    logic [TW-1:0]   r_tmo;
    logic [WW-1:0]   r_wcnt;
    logic            r_cs;
    logic            r_rd;
    logic            r_wr;
    logic [3:0]      r_addr;
    logic [7:0]      r_dout;
    logic            r_end_ack;
    logic            r_res_valid;
    logic [31:0]     r_res_data;
    logic            r_res_err;

    logic [7:0]      w_wr_byte [10];
    logic [3:0]      w_next_idx;
    logic [7:0]      w_next_byte;

    // Write image of the latched command: A bytes, B bytes, op, then the start write (data 0).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_opnd_bytes
            assign w_wr_byte[gi]     = r_a[8*gi +: 8];
            assign w_wr_byte[gi + 4] = r_b[8*gi +: 8];
        end
    endgenerate
    assign w_wr_byte[8] = r_op;
    assign w_wr_byte[9] = 8'h00;

    assign w_next_idx = r_idx + 4'd1;

    always_comb begin
        w_next_byte = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (w_next_idx == 4'(i)) begin
                w_next_byte = w_wr_byte[i];
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 4'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_op        <= 8'd0;
            r_tmo       <= '0;
            r_wcnt      <= '0;
            r_cs        <= 1'b1;
            r_rd        <= 1'b1;
            r_wr        <= 1'b1;
            r_addr      <= 4'd0;
            r_dout      <= 8'd0;
            r_end_ack   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'd0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_a        <= req_a;
                        r_b        <= req_b;
                        r_op       <= req_op;
                        r_res_data <= 32'd0;
                        r_res_err  <= 1'b0;
                        r_idx      <= 4'd0;
                        r_cs       <= 1'b0;
                        r_wr       <= 1'b1;
                        r_addr     <= 4'd0;
                        r_dout     <= req_a[7:0];
                        r_state    <= ST_WR_SETUP;
                    end
                end
                ST_WR_SETUP: begin
                    r_wr    <= 1'b0;
                    r_state <= ST_WR_STROBE;
                end
                ST_WR_STROBE: begin
                    r_wr    <= 1'b1;
                    r_state <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    if (r_idx == 4'd9) begin
                        r_cs    <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= ST_WAIT_END;
                    end else begin
                        r_idx   <= w_next_idx;
                        r_addr  <= w_next_idx;
                        r_dout  <= w_next_byte;
                        r_state <= ST_WR_SETUP;
                    end
                end
                ST_WAIT_END: begin
                    if (fpu_cmd_end) begin
                        r_cs    <= 1'b0;
                        r_rd    <= 1'b0;
                        r_addr  <= 4'd9;
                        r_idx   <= 4'd0;
                        r_wcnt  <= '0;
                        r_state <= ST_RD_BYTE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_cs        <= 1'b1;
                        r_rd        <= 1'b1;
                        r_wr        <= 1'b1;
                        r_end_ack   <= 1'b0;
                        r_res_data  <= 32'd0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_RD_BYTE: begin
                    // Sample on the last cycle of the hold window so the FPU has RD_WAIT cycles to drive.
                    if (r_wcnt == WAIT_LAST) begin
                        r_res_data[{r_idx[1:0], 3'b000} +: 8] <= fpu_din;
                        if (r_idx == 4'd3) begin
                            r_rd    <= 1'b1;
                            r_state <= ST_RD_END;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_addr <= r_addr + 4'd1;
                            r_wcnt <= '0;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                ST_RD_END: begin
                    r_cs      <= 1'b1;
                    r_end_ack <= 1'b1;
                    r_state   <= ST_ACK;
                end
                ST_ACK: begin
                    r_tmo   <= '0;
                    r_state <= ST_ACK_WAIT;
                end
                ST_ACK_WAIT: begin
                    if (!fpu_cmd_end) begin
                        r_end_ack   <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_cs        <= 1'b1;
                        r_rd        <= 1'b1;
                        r_wr        <= 1'b1;
                        r_end_ack   <= 1'b0;
                        r_res_data  <= 32'd0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign seq_busy    = (r_state != ST_IDLE);
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_err     = r_res_err;
    assign fpu_cs      = r_cs;
    assign fpu_rd      = r_rd;
    assign fpu_wr      = r_wr;
    assign fpu_addr    = r_addr;
    assign fpu_dout    = r_dout;
    assign fpu_end_ack = r_end_ack;

endmodule
